// File: rtl/max_pool_multi5_pkg.sv
// Shared constants and FP16 ordering helper for the 5x5 max-pool block.
package max_pool_multi5_pkg;

    localparam int FP16_W   = 16;
    localparam int POOL_K   = 5;
    localparam int WIN_N    = POOL_K * POOL_K;
    localparam int SIGN_BIT = 15;

    // True when a orders strictly above b; signed zeros compare equal.
    function automatic logic fp16_gt(input logic [FP16_W-1:0] a, input logic [FP16_W-1:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[SIGN_BIT-1:0] == 15'd0);
        b_zero = (b[SIGN_BIT-1:0] == 15'd0);
        if (a_zero && b_zero) begin
            fp16_gt = 1'b0;
        end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            fp16_gt = b[SIGN_BIT];
        end else if (a[SIGN_BIT] == 1'b0) begin
            fp16_gt = (a[SIGN_BIT-1:0] > b[SIGN_BIT-1:0]);
        end else begin
            fp16_gt = (a[SIGN_BIT-1:0] < b[SIGN_BIT-1:0]);
        end
    endfunction

endpackage

// File: rtl/max_pool_multi5_if.sv
// Flat tensor buses between the max-pool block and its producer/consumer.
interface max_pool_multi5_if
    import max_pool_multi5_pkg::*;
#(
    parameter int D = 1,
    parameter int H = 6,
    parameter int W = 6
);
    localparam int OH = H - POOL_K + 1;
    localparam int OW = W - POOL_K + 1;

    logic [0:H*W*D*FP16_W-1]   mpInput;
    logic [0:OH*OW*D*FP16_W-1] mpOutput;

    modport master (output mpInput, input mpOutput);
    modport slave  (input mpInput, output mpOutput);
endinterface

// File: rtl/max_pool_multi5_fp16_max2.sv
// Two-input FP16 maximum; on equal ordering the first operand is kept.
module fp16_max2
    import max_pool_multi5_pkg::*;
(
    input  logic [FP16_W-1:0] i_a,
    input  logic [FP16_W-1:0] i_b,
    output logic [FP16_W-1:0] o_max
);
    assign o_max = fp16_gt(i_b, i_a) ? i_b : i_a;
endmodule

// File: rtl/max_pool_multi5.sv
// 5x5 stride-1 FP16 max-pool producing one output element per clock into a
// registered flat output tensor.
module max_pool_multi5
    import max_pool_multi5_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 6,
    parameter int W          = 6
) (
    input  logic               clk,
    input  logic               reset,
    max_pool_multi5_if.slave   mp
);
    localparam int OH       = H - POOL_K + 1;
    localparam int OW       = W - POOL_K + 1;
    localparam int NOUT     = D * OH * OW;
    localparam int IN_BITS  = H * W * D * DATA_WIDTH;
    localparam int OUT_BITS = NOUT * DATA_WIDTH;
    localparam int IN_AW    = $clog2(IN_BITS);
    localparam int OUT_AW   = $clog2(OUT_BITS);
    localparam int IDX_W    = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int C_W      = (OW > 1) ? $clog2(OW) : 1;
    localparam int R_W      = (OH > 1) ? $clog2(OH) : 1;
    localparam int D_W      = (D > 1) ? $clog2(D) : 1;

    logic [IDX_W-1:0]       r_idx;
    logic [C_W-1:0]         r_c;
    logic [R_W-1:0]         r_r;
    logic [D_W-1:0]         r_d;
    logic                   r_done;
    logic [0:OUT_BITS-1]    r_out;

    logic [31:0]            w_base;
    logic [IN_AW-1:0]       w_pos  [WIN_N];
    logic [DATA_WIDTH-1:0]  w_win  [WIN_N];
    logic [DATA_WIDTH-1:0]  w_row  [POOL_K][POOL_K];
    logic [DATA_WIDTH-1:0]  w_col  [POOL_K];
    logic [DATA_WIDTH-1:0]  w_max;
    logic [OUT_AW-1:0]      w_opos;

    // Top-left input element of the current window, from the nested counters.
    assign w_base = 32'(r_d) * 32'(H * W) + 32'(r_r) * 32'(W) + 32'(r_c);
    assign w_opos = OUT_AW'(32'(r_idx) * 32'(DATA_WIDTH));

    genvar gi, gj;
    generate
        for (gi = 0; gi < POOL_K; gi++) begin : g_win_row
            for (gj = 0; gj < POOL_K; gj++) begin : g_win_col
                assign w_pos[gi*POOL_K+gj] =
                    IN_AW'((w_base + 32'(gi * W + gj)) * 32'(DATA_WIDTH));
                assign w_win[gi*POOL_K+gj] = mp.mpInput[w_pos[gi*POOL_K+gj] +: DATA_WIDTH];
            end
            // Left-to-right chain keeps the lower-index element on ties.
            assign w_row[gi][0] = w_win[gi*POOL_K];
            for (gj = 1; gj < POOL_K; gj++) begin : g_row_chain
                fp16_max2 u_row_max (
                    .i_a   (w_row[gi][gj-1]),
                    .i_b   (w_win[gi*POOL_K+gj]),
                    .o_max (w_row[gi][gj])
                );
            end
        end
        assign w_col[0] = w_row[0][POOL_K-1];
        for (gi = 1; gi < POOL_K; gi++) begin : g_col_chain
            fp16_max2 u_col_max (
                .i_a   (w_col[gi-1]),
                .i_b   (w_row[gi][POOL_K-1]),
                .o_max (w_col[gi])
            );
        end
    endgenerate

    assign w_max = w_col[POOL_K-1];

    // Output register, element index and window-position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_idx  <= '0;
            r_c    <= '0;
            r_r    <= '0;
            r_d    <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_out[w_opos +: DATA_WIDTH] <= w_max;
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(NOUT - 1)) begin
                r_done <= 1'b1;
            end
            if (r_c == C_W'(OW - 1)) begin
                r_c <= '0;
                if (r_r == R_W'(OH - 1)) begin
                    r_r <= '0;
                    r_d <= r_d + D_W'(1);
                end else begin
                    r_r <= r_r + R_W'(1);
                end
            end else begin
                r_c <= r_c + C_W'(1);
            end
        end
    end

    assign mp.mpOutput = r_out;

endmodule

// File: tb/tb_max_pool_multi5.sv
// Self-checking bench: a 6x6x1 and a 5x5x2 instance checked against a
// window-scan reference model using a signed ordering key.
module tb_max_pool_multi5;

    logic clk;
    logic reset;

    max_pool_multi5_if #(.D(1), .H(6), .W(6)) if_a ();
    max_pool_multi5_if #(.D(2), .H(5), .W(5)) if_b ();

    max_pool_multi5 #(.DATA_WIDTH(16), .D(1), .H(6), .W(6)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .mp    (if_a)
    );

    max_pool_multi5 #(.DATA_WIDTH(16), .D(2), .H(5), .W(5)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .mp    (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ya[$];
    logic [15:0] yb[$];

    // Ordering key: signed magnitude, so both zeros map to 0.
    function automatic int fkey(input logic [15:0] v);
        int m;
        m = int'({17'd0, v[14:0]});
        return v[15] ? -m : m;
    endfunction

    task automatic ref_pool(input logic [15:0] x[$], input int dd, input int hh, input int ww,
                            output logic [15:0] y[$]);
        logic [15:0] best;
        logic [15:0] e;
        y = {};
        for (int ch = 0; ch < dd; ch++)
            for (int rr = 0; rr <= hh - 5; rr++)
                for (int cc = 0; cc <= ww - 5; cc++) begin
                    best = x[ch*hh*ww + rr*ww + cc];
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++) begin
                            e = x[ch*hh*ww + (rr+i)*ww + cc + j];
                            if (fkey(e) > fkey(best)) best = e;
                        end
                    y.push_back(best);
                end
    endtask

    function automatic logic [0:63] pack_a(input logic [15:0] y[$], input int n);
        logic [0:63] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = (k < n) ? y[k] : 16'd0;
        return r;
    endfunction

    function automatic logic [0:31] pack_b(input logic [15:0] y[$], input int n);
        logic [0:31] r;
        r = '0;
        for (int k = 0; k < 2; k++) r[k*16 +: 16] = (k < n) ? y[k] : 16'd0;
        return r;
    endfunction

    function automatic logic [15:0] rnd_nz();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[14:0] == 15'd0) v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] rnd_neg();
        logic [15:0] v;
        v = rnd_nz();
        v[15] = 1'b1;
        return v;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < 36; k++) if_a.mpInput[k*16 +: 16] = qa[k];
        for (int k = 0; k < 50; k++) if_b.mpInput[k*16 +: 16] = qb[k];
    endtask

    task automatic fill_b_random();
        qb = {};
        for (int k = 0; k < 50; k++) qb.push_back(rnd_nz());
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_case1();
        qa = {};
        qa = {16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBD00, 16'hBC00};
        for (int k = 6; k < 36; k++) qa.push_back(16'hC200);
    endtask

    task automatic test_reset();
        load_case1();
        fill_b_random();
        @(negedge clk);
        drive_inputs();
        reset = 1'b1;
        edges(1);
        n_vec++;
        if (if_a.mpOutput !== 64'd0) begin
            n_err++;
            $display("FAIL reset_a: got %h want 0", if_a.mpOutput);
        end
        n_vec++;
        if (if_b.mpOutput !== 32'd0) begin
            n_err++;
            $display("FAIL reset_b: got %h want 0", if_b.mpOutput);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_case1();
        load_case1();
        pulse_reset();
        edges(4);
        n_vec++;
        if (if_a.mpOutput !== 64'hBC00BC00C200C200) begin
            n_err++;
            $display("FAIL case1: got %h want BC00BC00C200C200", if_a.mpOutput);
        end
    endtask

    task automatic test_first_slice();
        qa = {};
        for (int k = 0; k < 36; k++) qa.push_back(16'h3C00);
        pulse_reset();
        edges(1);
        n_vec++;
        if (if_a.mpOutput !== 64'h3C00000000000000) begin
            n_err++;
            $display("FAIL first_slice: got %h want 3C00000000000000", if_a.mpOutput);
        end
        edges(3);
        n_vec++;
        if (if_a.mpOutput !== {4{16'h3C00}}) begin
            n_err++;
            $display("FAIL all_ones: got %h want %h", if_a.mpOutput, {4{16'h3C00}});
        end
    endtask

    task automatic test_center_peak();
        qa = {};
        for (int k = 0; k < 36; k++) qa.push_back(rnd_neg());
        qa[14] = 16'h4500;
        pulse_reset();
        edges(4);
        n_vec++;
        if (if_a.mpOutput !== {4{16'h4500}}) begin
            n_err++;
            $display("FAIL center_peak: got %h want %h", if_a.mpOutput, {4{16'h4500}});
        end
        qa[14] = rnd_neg();
        qa[0]  = 16'h4500;
        ref_pool(qa, 1, 6, 6, ya);
        pulse_reset();
        edges(4);
        n_vec++;
        if (if_a.mpOutput[0:15] !== 16'h4500) begin
            n_err++;
            $display("FAIL corner_peak0: got %h want 4500", if_a.mpOutput[0:15]);
        end
        n_vec++;
        if (if_a.mpOutput !== pack_a(ya, 4)) begin
            n_err++;
            $display("FAIL corner_peak: got %h want %h", if_a.mpOutput, pack_a(ya, 4));
        end
    endtask

    task automatic test_zeros();
        logic [15:0] s;
        qa = {};
        for (int k = 0; k < 36; k++) qa.push_back({1'($urandom), 15'd0});
        pulse_reset();
        edges(4);
        for (int k = 0; k < 4; k++) begin
            s = if_a.mpOutput[k*16 +: 16];
            n_vec++;
            if (s[14:0] !== 15'd0) begin
                n_err++;
                $display("FAIL signed_zero[%0d]: got %h want 0000 or 8000", k, s);
            end
        end
        qa = {};
        for (int k = 0; k < 36; k++) qa.push_back(16'hC000);
        qa[14] = 16'hBC00;
        pulse_reset();
        edges(4);
        n_vec++;
        if (if_a.mpOutput !== {4{16'hBC00}}) begin
            n_err++;
            $display("FAIL neg_order: got %h want %h", if_a.mpOutput, {4{16'hBC00}});
        end
    endtask

    task automatic test_two_channel();
        qb = {};
        for (int k = 0; k < 25; k++) qb.push_back(rnd_neg());
        for (int k = 0; k < 25; k++) qb.push_back({1'b1, 15'($urandom_range(32'h4101, 32'h7FFF))});
        qb[$urandom_range(0, 24)]  = 16'h4000;
        qb[$urandom_range(25, 49)] = 16'hC100;
        pulse_reset();
        edges(1);
        n_vec++;
        if (if_b.mpOutput !== 32'h40000000) begin
            n_err++;
            $display("FAIL two_ch_partial: got %h want 40000000", if_b.mpOutput);
        end
        edges(1);
        n_vec++;
        if (if_b.mpOutput !== 32'h4000C100) begin
            n_err++;
            $display("FAIL two_ch: got %h want 4000C100", if_b.mpOutput);
        end
    endtask

    task automatic test_reset_midrun();
        load_case1();
        pulse_reset();
        edges(2);
        n_vec++;
        if (if_a.mpOutput !== 64'hBC00BC0000000000) begin
            n_err++;
            $display("FAIL midrun_partial: got %h want BC00BC0000000000", if_a.mpOutput);
        end
        @(negedge clk);
        reset = 1'b1;
        edges(1);
        n_vec++;
        if (if_a.mpOutput !== 64'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got %h want 0", if_a.mpOutput);
        end
        @(negedge clk);
        reset = 1'b0;
        edges(3);
        n_vec++;
        if (if_a.mpOutput !== 64'hBC00BC00C2000000) begin
            n_err++;
            $display("FAIL restart_partial: got %h want BC00BC00C2000000", if_a.mpOutput);
        end
        edges(1);
        n_vec++;
        if (if_a.mpOutput !== 64'hBC00BC00C200C200) begin
            n_err++;
            $display("FAIL restart_full: got %h want BC00BC00C200C200", if_a.mpOutput);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            qa = {};
            for (int k = 0; k < 36; k++) qa.push_back(rnd_nz());
            fill_b_random();
            ref_pool(qa, 1, 6, 6, ya);
            ref_pool(qb, 2, 5, 5, yb);
            pulse_reset();
            for (int e = 1; e <= 4; e++) begin
                edges(1);
                n_vec++;
                if (if_a.mpOutput !== pack_a(ya, e)) begin
                    n_err++;
                    $display("FAIL rand_a it%0d edge%0d: got %h want %h",
                             it, e, if_a.mpOutput, pack_a(ya, e));
                end
                if (e <= 2) begin
                    n_vec++;
                    if (if_b.mpOutput !== pack_b(yb, e)) begin
                        n_err++;
                        $display("FAIL rand_b it%0d edge%0d: got %h want %h",
                                 it, e, if_b.mpOutput, pack_b(yb, e));
                    end
                end
            end
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 36; k++) qa[k] = rnd_nz();
        for (int k = 0; k < 50; k++) qb[k] = rnd_nz();
        @(negedge clk);
        drive_inputs();
        edges(5);
        n_vec++;
        if (if_a.mpOutput !== pack_a(ya, 4)) begin
            n_err++;
            $display("FAIL hold_a: got %h want %h", if_a.mpOutput, pack_a(ya, 4));
        end
        n_vec++;
        if (if_b.mpOutput !== pack_b(yb, 2)) begin
            n_err++;
            $display("FAIL hold_b: got %h want %h", if_b.mpOutput, pack_b(yb, 2));
        end
    endtask

    initial begin
        reset = 1'b0;
        if_a.mpInput = '0;
        if_b.mpInput = '0;
        test_reset();
        test_case1();
        test_first_slice();
        test_center_peak();
        test_zeros();
        test_two_channel();
        test_reset_midrun();
        test_random();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
